// File: rtl/dsram_pkg.sv
// Shared types and helpers for the data SRAM responder: word/lane sizes,
// the INIT/RUN state type, the request payload and the byte-lane merge.
package dsram_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dsram_state_e;

    typedef struct packed {
        logic              en;
        logic [LANES-1:0]  wen;
        logic [31:0]       addr;
        logic [WORD_W-1:0] wdata;
    } dsram_req_t;

    // Replace the bytes of old_w selected by wen with the matching bytes of new_w.
    function automatic logic [WORD_W-1:0] byte_merge(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [LANES-1:0]  wen
    );
        logic [WORD_W-1:0] merged;
        merged = old_w;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (wen[i]) begin
                merged[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dsram_init_seq.sv
// Post-reset clear sequencer: walks every word index once in INIT, then
// parks in RUN and raises init_done one cycle later.
module dsram_init_seq
    import dsram_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_idx_o,
    output logic              init_done_o
);

    dsram_state_e      state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              done_q, done_d;
    logic              clr_we_q, clr_we_d;

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q  <= INIT;
            idx_q    <= '0;
            done_q   <= 1'b0;
            clr_we_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            clr_we_q <= clr_we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = done_q;
        unique case (state_q)
            INIT: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == {ADDR_W{1'b1}}) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
        // Registered so the array port sees a flop-driven clear enable.
        clr_we_d = (state_d == INIT);
    end

    assign clr_we_o    = clr_we_q;
    assign clr_idx_o   = idx_q;
    assign init_done_o = done_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: byte-lane writable word array with 1-cycle read,
// post-reset clear and window check. DSRAM_PERF_CNT_EN adds rd_cnt/wr_cnt.
module data_sram_responder
    import dsram_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sram_en,
    input  logic [LANES-1:0]  sram_wen,
    input  logic [31:0]       sram_addr,
    input  logic [WORD_W-1:0] sram_wdata,
    output logic [WORD_W-1:0] sram_rdata,
    output logic              init_done,
    output logic              addr_err
`ifdef DSRAM_PERF_CNT_EN
    ,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt
`endif
);

    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam logic [32:0] WIN_BYTES = 33'(1) << (ADDR_W + 2);

    dsram_req_t        req;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic [31:0]       off;
    logic              in_win;
    logic [ADDR_W-1:0] idx;
    logic              acc, rd_acc, wr_acc, oow;
    logic [WORD_W-1:0] merged;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              addr_err_q, addr_err_d;

    assign req = '{en: sram_en, wen: sram_wen, addr: sram_addr, wdata: sram_wdata};

    dsram_init_seq #(
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .clk         (clk),
        .resetn      (resetn),
        .clr_we_o    (clr_we),
        .clr_idx_o   (clr_idx),
        .init_done_o (init_done)
    );

    // Window decode: wrapping offset, upper bound checked at 33 bits.
    assign off    = req.addr - BASE_ADDR;
    assign in_win = ({1'b0, off} < WIN_BYTES);
    assign idx    = off[ADDR_W+1:2];

    assign acc    = req.en & ~clr_we;
    assign rd_acc = acc & in_win & (req.wen == '0);
    assign wr_acc = acc & in_win & (req.wen != '0);
    assign oow    = acc & ~in_win;
    assign merged = byte_merge(mem_q[idx], req.wdata, req.wen);

    // Clear writes own the array port while INIT is active.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_idx] <= '0;
        end else if (wr_acc) begin
            mem_q[idx] <= merged;
        end
    end

    always_comb begin
        rdata_d    = rdata_q;
        addr_err_d = oow;
        if (rd_acc) begin
            rdata_d = mem_q[idx];
        end else if (wr_acc) begin
            rdata_d = merged;
        end else if (oow) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            rdata_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign sram_rdata = rdata_q;
    assign addr_err   = addr_err_q;

`ifdef DSRAM_PERF_CNT_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk) begin
        if (resetn) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_acc) rd_cnt_q <= rd_cnt_q + 32'd1;
            if (wr_acc) wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder (ADDR_W=4, BASE_ADDR=32'h1000).
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        sram_en = 1'b0;
    logic [3:0]  sram_wen = 4'h0;
    logic [31:0] sram_addr = 32'h0;
    logic [31:0] sram_wdata = 32'h0;
    logic [31:0] sram_rdata;
    logic        init_done;
    logic        addr_err;
`ifdef DSRAM_PERF_CNT_EN
    logic [31:0] rd_cnt, wr_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    data_sram_responder #(
        .ADDR_W    (4),
        .BASE_ADDR (32'h0000_1000)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .init_done  (init_done),
        .addr_err   (addr_err)
`ifdef DSRAM_PERF_CNT_EN
        ,
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one request, then sample 1ns after the edge that captures it.
    task automatic cyc(input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wd);
        sram_en    = en;
        sram_wen   = wen;
        sram_addr  = addr;
        sram_wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        idle();
        resetn = 1'b0;
        chk("rst_rdata", sram_rdata, 32'h0);
        chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
        chk("rst_init_done", {31'h0, init_done}, 32'h0);
    endtask

    // 16 edges after release keep init_done low; the 17th raises it.
    task automatic wait_init(input string tag);
        for (int i = 1; i <= 16; i++) begin
            idle();
            chk({tag, "_low"}, {31'h0, init_done}, 32'h0);
        end
        idle();
        chk({tag, "_rise17"}, {31'h0, init_done}, 32'h1);
    endtask

    initial begin
        // Reset and clear
        do_reset();
        wait_init("init1");
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 4'h0, 32'h1000 + 32'(4 * i), 32'h0);
            chk("clear_read", sram_rdata, 32'h0);
        end

        // Byte-lane writes to word 2
        cyc(1'b1, 4'b1111, 32'h1008, 32'hAABBCCDD);
        chk("wr_full_rdata", sram_rdata, 32'hAABBCCDD);
        cyc(1'b1, 4'b0101, 32'h1008, 32'h11223344);
        chk("wr_lane_rdata", sram_rdata, 32'hAA22CC44);
        cyc(1'b1, 4'b0000, 32'h1008, 32'h0);
        chk("rd_lane", sram_rdata, 32'hAA22CC44);
        chk("rd_lane_err", {31'h0, addr_err}, 32'h0);

        // Back-to-back write then read, then idle hold
        cyc(1'b1, 4'b1111, 32'h1010, 32'hCAFEF00D);
        cyc(1'b1, 4'b0000, 32'h1010, 32'h0);
        chk("b2b_read", sram_rdata, 32'hCAFEF00D);
        idle();
        chk("idle_hold", sram_rdata, 32'hCAFEF00D);
        chk("idle_err", {31'h0, addr_err}, 32'h0);
        cyc(1'b1, 4'b0000, 32'h100A, 32'h0);
        chk("rd_low_bits_ignored", sram_rdata, 32'hAA22CC44);

        // Window boundaries
        cyc(1'b1, 4'b1111, 32'h103C, 32'h12345678);
        chk("top_word_wr", sram_rdata, 32'h12345678);
        chk("top_word_err", {31'h0, addr_err}, 32'h0);
        cyc(1'b1, 4'b1111, 32'h1040, 32'hDEADBEEF);
        chk("oow_hi_err", {31'h0, addr_err}, 32'h1);
        chk("oow_hi_rdata", sram_rdata, 32'h0);
        idle();
        chk("oow_err_pulse", {31'h0, addr_err}, 32'h0);
        cyc(1'b1, 4'b0000, 32'h0FFC, 32'h0);
        chk("oow_lo_err", {31'h0, addr_err}, 32'h1);
        cyc(1'b1, 4'b0000, 32'h1000, 32'h0);
        chk("no_alias_word0", sram_rdata, 32'h0);
        chk("no_alias_err", {31'h0, addr_err}, 32'h0);
        cyc(1'b1, 4'b0000, 32'h103C, 32'h0);
        chk("top_word_rd", sram_rdata, 32'h12345678);

        // Reset mid-RUN clears the array
        do_reset();
        wait_init("init2");
        cyc(1'b1, 4'b0000, 32'h1008, 32'h0);
        chk("reclear_w2", sram_rdata, 32'h0);
        cyc(1'b1, 4'b0000, 32'h1010, 32'h0);
        chk("reclear_w4", sram_rdata, 32'h0);
        cyc(1'b1, 4'b0000, 32'h103C, 32'h0);
        chk("reclear_w15", sram_rdata, 32'h0);

        // Reset mid-INIT at clear index 7, requests during INIT dropped
        do_reset();
        for (int i = 0; i < 7; i++) idle();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            if (i % 2 == 0) cyc(1'b1, 4'b1111, 32'h1000, 32'hFFFFFFFF);
            else            cyc(1'b1, 4'b0000, 32'h2000, 32'h0);
            chk("init_req_rdata", sram_rdata, 32'h0);
            chk("init_req_err", {31'h0, addr_err}, 32'h0);
            chk("init3_low", {31'h0, init_done}, 32'h0);
        end
        idle();
        chk("init3_rise17", {31'h0, init_done}, 32'h1);
`ifdef DSRAM_PERF_CNT_EN
        chk("cnt_rd_init", rd_cnt, 32'd0);
        chk("cnt_wr_init", wr_cnt, 32'd0);
`endif

        // Mixed traffic: 3 reads, 2 writes, 1 out-of-window, 1 idle
        cyc(1'b1, 4'b0000, 32'h1000, 32'h0);
        chk("init_wr_dropped", sram_rdata, 32'h0);
        cyc(1'b1, 4'b0011, 32'h1004, 32'h12345678);
        chk("mix_wr1", sram_rdata, 32'h00005678);
        cyc(1'b1, 4'b0000, 32'h1004, 32'h0);
        chk("mix_rd1", sram_rdata, 32'h00005678);
        cyc(1'b1, 4'b1000, 32'h1008, 32'h99AABBCC);
        chk("mix_wr2", sram_rdata, 32'h99000000);
        cyc(1'b1, 4'b1111, 32'h0000, 32'h55555555);
        chk("mix_oow_err", {31'h0, addr_err}, 32'h1);
        idle();
        cyc(1'b1, 4'b0000, 32'h1008, 32'h0);
        chk("mix_rd2", sram_rdata, 32'h99000000);
`ifdef DSRAM_PERF_CNT_EN
        chk("cnt_rd", rd_cnt, 32'd3);
        chk("cnt_wr", wr_cnt, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Responder end of the core's data SRAM port: it accepts the `en/wen/addr/wdata` requests the pipeline's MEM stage issues and returns `rdata` one cycle later, so the value is available to WB. It holds a byte-lane-writable word array. After every reset it runs a clear sequence that zeroes the array. Out-of-window addresses are flagged instead of aliased. It sits beside the core top as the data-memory model for simulation and FPGA bring-up.

## Interface

**Parameters**
- `ADDR_W`, default 10: word-address width; depth is 2^ADDR_W 32-bit words.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be 4-byte aligned.

**Ports**
- `clk` input 1: single clock, rising edge.
- `resetn` input 1: reset, synchronous, active-high (same port name and polarity the core uses).
- `sram_en` input 1: access request this cycle.
- `sram_wen` input 4: byte-lane write enables; lane i covers bits [8i+7:8i]. A value of 0 means read.
- `sram_addr` input 32: byte address.
- `sram_wdata` input 32: write data; lanes align with `sram_wen`.
- `sram_rdata` output 32: registered read data.
- `init_done` output 1: high once the clear sequence has finished.
- `addr_err` output 1: registered one-cycle pulse for an out-of-window access.
- `rd_cnt`, `wr_cnt` output 32 each: accepted read/write counts; present only with `DSRAM_PERF_CNT_EN`.

## Operation

**States:** `INIT` and `RUN`.
- Reset forces `INIT`, with clear index = 0.

**INIT:**
- Each cycle writes 0 to word[index], then increments the index.
- After writing index 2^ADDR_W−1, moves to `RUN` and asserts `init_done` the next cycle.
- Requests during `INIT` are dropped: no write, no counter change, `sram_rdata` stays 0, `addr_err` stays 0.

**Address decode:**
- off = `sram_addr` − `BASE_ADDR` (32-bit, wraps).
- In window if off < 4·2^ADDR_W; word index = off[ADDR_W+1:2]. off[1:0] is ignored; byte steering is the core's job.

**RUN, read** (`en`=1, `wen`=0, in window):
- `sram_rdata` ← word[idx] at the next edge.

**RUN, write** (`en`=1, `wen`≠0, in window):
- Only the enabled lanes of word[idx] update.
- `sram_rdata` ← the merged new word (write-first).

**RUN, out of window:**
- No array change.
- `sram_rdata` ← 32'h0 and `addr_err` ← 1 for one cycle.

**Idle** (`en`=0): `sram_rdata` holds its last value; `addr_err` ← 0.

**Back-to-back:**
- A write to X followed by a read of X on the next cycle returns the written data. No bubble is required.
- The port accepts one access every cycle.

## Timing

- **Reset values:** `sram_rdata`=0, `init_done`=0, `addr_err`=0, `rd_cnt`=`wr_cnt`=0, state=`INIT`, index=0.
- **Clear duration:**
  - `init_done` rises exactly 2^ADDR_W+1 cycles after the cycle in which `resetn` is sampled low.
  - It stays high until the next reset.
- **Read latency:** 1 cycle. A request sampled at edge N gives `sram_rdata` valid after edge N+1 for WB.
- **`addr_err` timing:** aligned with the `sram_rdata` of the offending request.
- **Reset mid-INIT or mid-RUN:** the clear restarts from index 0. Array contents are undefined until `init_done` rises.

## Configuration

- `DSRAM_PERF_CNT_EN` defined:
  - `rd_cnt` and `wr_cnt` exist and increment by 1 per accepted in-window read/write in `RUN`.
  - Both wrap at 2^32 and clear on reset.
- `DSRAM_PERF_CNT_EN` undefined: both ports and their logic are absent.

## Structure

**Shared package `dsram_pkg`:**
- State typedef (`INIT`, `RUN`).
- `WORD_W`=32, `LANES`=4.
- Byte-merge function: (old, new, wen) → merged word.

**Sub-module `dsram_init_seq`:**
- Contains the clear-index counter and the `INIT`→`RUN` FSM.
- Outputs the clear write-enable, the clear index and `init_done`.
- The top muxes the clear write onto the array port.

## Test plan

1. **Reset and clear (ADDR_W=4):**
   - Hold reset 1 cycle, release.
   - `init_done` rises at cycle 17.
   - Reads of all 16 words return 0.
2. **Byte-lane write:**
   - Write 32'hAABBCCDD with wen=4'b1111 to addr 0x8.
   - Then write 32'h11223344 with wen=4'b0101 to addr 0x8.
   - A read of 0x8 returns 32'hAA22CC44.
3. **Back-to-back write then read:**
   - Write 32'hCAFEF00D to 0x10, then read 0x10 on the next cycle.
   - `sram_rdata` = 32'hCAFEF00D one cycle after the read.
4. **Out of window (BASE_ADDR=32'h1000, ADDR_W=4):**
   - Write to 0x1040 → `addr_err`=1 for one cycle, `sram_rdata`=0, no write.
   - Access to 0x0FFC → also flagged.
5. **Reset mid-INIT:**
   - Assert reset at clear index 7.
   - The index returns to 0, `init_done` stays 0, and it rises 17 cycles after reset release.
   - Requests issued during INIT give `sram_rdata`=0 and no `addr_err`.
6. **Counters (`DSRAM_PERF_CNT_EN` defined):**
   - Issue 3 reads, 2 writes, 1 out-of-window access and 1 idle cycle.
   - Result: `rd_cnt`=3, `wr_cnt`=2.
